// File: rtl/conv_pkg.sv
// Shared definitions for the convolution line-buffer routing path.
package conv_pkg;

  // Default geometry of the line-buffer / slab banks.
  localparam int unsigned ROWS_DEF     = 3;
  localparam int unsigned BANKS_DEF    = 3;
  localparam int unsigned PIX_DEF      = 32;
  localparam int unsigned SLAB_PIX_DEF = 2;
  localparam int unsigned ADR_W_DEF    = 16;

  // Width of a bank index where index 0 means "no bank".
  function automatic int unsigned idx_width(input int unsigned banks);
    return $clog2(banks + 1);
  endfunction

  localparam int unsigned IDX_W_DEF = idx_width(BANKS_DEF);

  // One tracking-pipeline stage at the default geometry.
  typedef struct packed {
    logic [ROWS_DEF-1:0][IDX_W_DEF-1:0] grant_idx;
    logic [BANKS_DEF-1:0]               issued;
    logic [BANKS_DEF-1:0][ADR_W_DEF-1:0] adr;
  } pipe_stage_t;

endpackage

// File: rtl/conv_bank_router_arbiter.sv
// Per-bank request selector: lowest-numbered requesting row wins, any
// further requester for the same bank is reported as dropped.
module bank_arbiter
  import conv_pkg::*;
#(
  parameter int unsigned ROWS    = ROWS_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF,
  parameter int unsigned BANK_ID = 1
) (
  input  logic                  en_i,
  input  logic [ROWS-1:0]       row_valid_i,
  input  logic [ROWS*IDX_W-1:0] row_idx_i,
  output logic [ROWS-1:0]       win_oh_o,
  output logic                  drop_o
);

  logic [ROWS-1:0] match_s;
  logic [ROWS-1:0] seen_s;

  // Match each row against this bank's index and keep only the first match.
  always_comb begin
    match_s  = '0;
    seen_s   = '0;
    win_oh_o = '0;
    drop_o   = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      match_s[r] = en_i & row_valid_i[r] &
                   (row_idx_i[r*IDX_W +: IDX_W] == IDX_W'(BANK_ID));
      seen_s[r]   = (r == 0) ? 1'b0 : (seen_s[(r == 0) ? 0 : r-1] | match_s[(r == 0) ? 0 : r-1]);
      win_oh_o[r] = match_s[r] & ~seen_s[r];
      drop_o      = drop_o | (match_s[r] & seen_s[r]);
    end
  end

endmodule

// File: rtl/conv_bank_router.sv
// Row-to-bank router: issues kernel-row reads onto buffer/slab banks, tracks
// ownership for RD_LAT cycles to steer returned data back to its row, writes
// the low slab pixels back to the slab bank and counts bank conflicts.
module conv_bank_router
  import conv_pkg::*;
#(
  parameter int unsigned ROWS     = ROWS_DEF,
  parameter int unsigned BANKS    = BANKS_DEF,
  parameter int unsigned PIX      = PIX_DEF,
  parameter int unsigned SLAB_PIX = SLAB_PIX_DEF,
  parameter int unsigned ADR_W    = ADR_W_DEF,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned IDX_W    = idx_width(BANKS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [ROWS*ADR_W-1:0]        row_adr,
  input  logic [ROWS*IDX_W-1:0]        row_idx,
  input  logic [ROWS-1:0]              row_valid,
  output logic [BANKS*ADR_W-1:0]       bank_adr,
  output logic [BANKS-1:0]             bank_rd_en,
  input  logic [BANKS*PIX*8-1:0]       bank_rdata,
  input  logic [BANKS*SLAB_PIX*8-1:0]  slab_rdata,
  output logic [ROWS*PIX*8-1:0]        row_rdata,
  output logic [ROWS*SLAB_PIX*8-1:0]   row_slab,
  output logic [ROWS-1:0]              row_rvalid,
  output logic [BANKS*ADR_W-1:0]       slab_wr_adr,
  output logic [BANKS*SLAB_PIX*8-1:0]  slab_wr_data,
  output logic [BANKS-1:0]             slab_wr_en,
  output logic                         conflict,
  output logic [15:0]                  conflict_cnt
);

  localparam int unsigned DW = PIX * 8;
  localparam int unsigned SW = SLAB_PIX * 8;

  typedef struct packed {
    logic [ROWS-1:0][IDX_W-1:0]  grant_idx;
    logic [BANKS-1:0]            issued;
    logic [BANKS-1:0][ADR_W-1:0] adr;
  } stage_t;

  // Nothing is issued while reset is held, so bank outputs read as zero.
  logic issue_en_s;
  assign issue_en_s = en & ~reset;

  logic [BANKS-1:0][ROWS-1:0] win_oh_s;
  logic [BANKS-1:0]           drop_s;

  for (genvar b = 0; b < BANKS; b++) begin : g_arb
    bank_arbiter #(
      .ROWS    (ROWS),
      .IDX_W   (IDX_W),
      .BANK_ID (b + 1)
    ) u_arb (
      .en_i        (issue_en_s),
      .row_valid_i (row_valid),
      .row_idx_i   (row_idx),
      .win_oh_o    (win_oh_s[b]),
      .drop_o      (drop_s[b])
    );
  end

  stage_t stage_d;

  // Build this cycle's issue record and drive the bank read ports from it.
  always_comb begin
    stage_d    = '0;
    bank_adr   = '0;
    for (int b = 0; b < BANKS; b++) begin
      stage_d.issued[b] = |win_oh_s[b];
      for (int r = 0; r < ROWS; r++) begin
        stage_d.grant_idx[r] = stage_d.grant_idx[r] |
                               (win_oh_s[b][r] ? IDX_W'(b + 1) : {IDX_W{1'b0}});
        stage_d.adr[b]       = stage_d.adr[b] |
                               (win_oh_s[b][r] ? row_adr[r*ADR_W +: ADR_W] : {ADR_W{1'b0}});
      end
      bank_adr[b*ADR_W +: ADR_W] = stage_d.adr[b];
    end
    bank_rd_en = stage_d.issued;
  end

  stage_t pipe_q [RD_LAT];

  // Ownership pipeline: advances every cycle so in-flight reads drain even with en low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= stage_d;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  stage_t tail_s;
  assign tail_s = pipe_q[RD_LAT-1];

  // Steer returned bank data to the row that owned the bank at issue time.
  always_comb begin
    row_rvalid = '0;
    row_rdata  = '0;
    row_slab   = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_rvalid[r] = |tail_s.grant_idx[r];
      for (int b = 0; b < BANKS; b++) begin
        row_rdata[r*DW +: DW] = row_rdata[r*DW +: DW] |
            ((tail_s.grant_idx[r] == IDX_W'(b + 1)) ? bank_rdata[b*DW +: DW] : {DW{1'b0}});
        row_slab[r*SW +: SW]  = row_slab[r*SW +: SW] |
            ((tail_s.grant_idx[r] == IDX_W'(b + 1)) ? slab_rdata[b*SW +: SW] : {SW{1'b0}});
      end
    end
  end

  // Write the low slab pixels of each returned buffer word back to its slab bank.
  always_comb begin
    slab_wr_en   = tail_s.issued;
    slab_wr_adr  = '1;
    slab_wr_data = '0;
    for (int b = 0; b < BANKS; b++) begin
      slab_wr_adr[b*ADR_W +: ADR_W] = tail_s.issued[b] ? tail_s.adr[b] : {ADR_W{1'b1}};
      slab_wr_data[b*SW +: SW]      = tail_s.issued[b] ? bank_rdata[b*DW +: SW] : {SW{1'b0}};
    end
  end

  logic        conflict_q;
  logic [15:0] conflict_cnt_q;

  // Sticky conflict flag and saturating count of cycles that dropped a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_q     <= 1'b0;
      conflict_cnt_q <= 16'h0000;
    end else if (|drop_s) begin
      conflict_q     <= 1'b1;
      conflict_cnt_q <= (conflict_cnt_q == 16'hFFFF) ? 16'hFFFF : conflict_cnt_q + 16'd1;
    end else begin
      conflict_q     <= conflict_q;
      conflict_cnt_q <= conflict_cnt_q;
    end
  end

  assign conflict     = conflict_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_conv_bank_router.sv
// Bench for conv_bank_router: three instances (RD_LAT 1, 2, 3) share the same
// stimulus and are compared every cycle against a request-history model.
module tb_conv_bank_router;

  localparam int ROWS  = 3;
  localparam int BANKS = 3;
  localparam int PIX   = 32;
  localparam int SP    = 2;
  localparam int AW    = 16;
  localparam int IW    = 2;
  localparam int DW    = PIX * 8;
  localparam int SW    = SP * 8;
  localparam int ND    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic [ROWS*AW-1:0]   row_adr = '0;
  logic [ROWS*IW-1:0]   row_idx = '0;
  logic [ROWS-1:0]      row_valid = '0;
  logic [BANKS*DW-1:0]  bank_rdata = '0;
  logic [BANKS*SW-1:0]  slab_rdata = '0;

  logic [BANKS*AW-1:0]  bank_adr_w     [ND];
  logic [BANKS-1:0]     bank_rd_en_w   [ND];
  logic [ROWS*DW-1:0]   row_rdata_w    [ND];
  logic [ROWS*SW-1:0]   row_slab_w     [ND];
  logic [ROWS-1:0]      row_rvalid_w   [ND];
  logic [BANKS*AW-1:0]  slab_wr_adr_w  [ND];
  logic [BANKS*SW-1:0]  slab_wr_data_w [ND];
  logic [BANKS-1:0]     slab_wr_en_w   [ND];
  logic                 conflict_w     [ND];
  logic [15:0]          conflict_cnt_w [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    conv_bank_router #(
      .ROWS(ROWS), .BANKS(BANKS), .PIX(PIX), .SLAB_PIX(SP), .ADR_W(AW), .RD_LAT(g + 1)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .row_adr      (row_adr),
      .row_idx      (row_idx),
      .row_valid    (row_valid),
      .bank_adr     (bank_adr_w[g]),
      .bank_rd_en   (bank_rd_en_w[g]),
      .bank_rdata   (bank_rdata),
      .slab_rdata   (slab_rdata),
      .row_rdata    (row_rdata_w[g]),
      .row_slab     (row_slab_w[g]),
      .row_rvalid   (row_rvalid_w[g]),
      .slab_wr_adr  (slab_wr_adr_w[g]),
      .slab_wr_data (slab_wr_data_w[g]),
      .slab_wr_en   (slab_wr_en_w[g]),
      .conflict     (conflict_w[g]),
      .conflict_cnt (conflict_cnt_w[g])
    );
  end

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Request history: which bank (1..BANKS, 0 none) each row was granted and
  // with which address, per clock edge number.
  int rec_g [16][ROWS];
  int rec_a [16][ROWS];
  int cyc      = 0;
  int last_rst = 0;
  int m_cnt    = 0;
  bit m_conf   = 1'b0;

  task automatic check(input string nm, input int d, input logic [767:0] act, input logic [767:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
    end
  endtask

  // A row is served when it is a valid in-range request and no earlier row
  // asked for the same bank; otherwise, if it asked, it is dropped.
  task automatic req_model(output int g [ROWS], output bit drop);
    drop = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      int want;
      bit taken;
      g[r]  = 0;
      want  = int'(row_idx[r*IW +: IW]);
      taken = 1'b0;
      if (!reset && en && row_valid[r] && want >= 1 && want <= BANKS) begin
        for (int q = 0; q < r; q++) begin
          if (row_valid[q] && int'(row_idx[q*IW +: IW]) == want) taken = 1'b1;
        end
        if (taken) drop = 1'b1;
        else g[r] = want;
      end
    end
  endtask

  // Model update on every clock edge.
  always @(posedge clk) begin
    int g [ROWS];
    bit drop;
    cyc = cyc + 1;
    req_model(g, drop);
    for (int r = 0; r < ROWS; r++) begin
      rec_g[cyc % 16][r] = g[r];
      rec_a[cyc % 16][r] = int'(row_adr[r*AW +: AW]);
    end
    if (reset) begin
      last_rst = cyc;
      m_cnt    = 0;
      m_conf   = 1'b0;
    end else if (drop) begin
      m_conf = 1'b1;
      if (m_cnt != 65535) m_cnt = m_cnt + 1;
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    int g [ROWS];
    bit drop;
    logic [BANKS*AW-1:0] e_badr;
    logic [BANKS-1:0]    e_ben;
    req_model(g, drop);
    e_badr = '0;
    e_ben  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (g[r] != 0) begin
        e_ben[g[r]-1] = 1'b1;
        e_badr[(g[r]-1)*AW +: AW] = row_adr[r*AW +: AW];
      end
    end
    for (int d = 0; d < ND; d++) begin
      int c;
      bit live;
      logic [ROWS-1:0]     e_rv;
      logic [ROWS*DW-1:0]  e_rd;
      logic [ROWS*SW-1:0]  e_rs;
      logic [BANKS-1:0]    e_wen;
      logic [BANKS*AW-1:0] e_wadr;
      logic [BANKS*SW-1:0] e_wdat;
      c    = cyc - d;
      live = !reset && c >= 1 && c > last_rst;
      e_rv = '0; e_rd = '0; e_rs = '0; e_wen = '0; e_wadr = '1; e_wdat = '0;
      for (int r = 0; r < ROWS; r++) begin
        int gb;
        gb = live ? rec_g[c % 16][r] : 0;
        if (gb != 0) begin
          e_rv[r] = 1'b1;
          e_rd[r*DW +: DW] = bank_rdata[(gb-1)*DW +: DW];
          e_rs[r*SW +: SW] = slab_rdata[(gb-1)*SW +: SW];
          e_wen[gb-1] = 1'b1;
          e_wadr[(gb-1)*AW +: AW] = AW'(rec_a[c % 16][r]);
          e_wdat[(gb-1)*SW +: SW] = bank_rdata[(gb-1)*DW +: SW];
        end
      end
      check("bank_adr", d, bank_adr_w[d], e_badr);
      check("bank_rd_en", d, bank_rd_en_w[d], e_ben);
      check("row_rvalid", d, row_rvalid_w[d], e_rv);
      check("row_rdata", d, row_rdata_w[d], e_rd);
      check("row_slab", d, row_slab_w[d], e_rs);
      check("slab_wr_en", d, slab_wr_en_w[d], e_wen);
      check("slab_wr_adr", d, slab_wr_adr_w[d], e_wadr);
      check("slab_wr_data", d, slab_wr_data_w[d], e_wdat);
      check("conflict", d, conflict_w[d], reset ? 1'b0 : m_conf);
      check("conflict_cnt", d, conflict_cnt_w[d], reset ? 16'h0000 : 16'(m_cnt));
    end
  end

  bit hold_data = 1'b0;

  task automatic step();
    @(posedge clk);
    #2;
    if (!hold_data) begin
      for (int i = 0; i < BANKS*DW/32; i++) bank_rdata[i*32 +: 32] = $urandom;
      slab_rdata = {$urandom, $urandom};
    end
  endtask

  task automatic set_row(input int r, input bit v, input int idx, input int adr);
    row_valid[r]        = v;
    row_idx[r*IW +: IW] = IW'(idx);
    row_adr[r*AW +: AW] = AW'(adr);
  endtask

  task automatic idle();
    for (int r = 0; r < ROWS; r++) set_row(r, 1'b0, 0, 0);
  endtask

  initial begin
    logic [BANKS*DW-1:0] pat;
    pat = {{32{8'h33}}, {32{8'h22}}, {32{8'h11}}};

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", 0, row_rvalid_w[0], 3'b000);
    check("rst_wr_adr", 1, slab_wr_adr_w[1], 48'hFFFF_FFFF_FFFF);
    check("rst_cnt", 2, conflict_cnt_w[2], 16'h0000);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step();

    // Rows 1/2/3 to banks 1/2/3.
    hold_data = 1'b1;
    bank_rdata = pat;
    en = 1'b1;
    set_row(0, 1'b1, 1, 5);
    set_row(1, 1'b1, 2, 6);
    set_row(2, 1'b1, 3, 7);
    #3;
    check("t1_bank_adr", 0, bank_adr_w[0], {16'd7, 16'd6, 16'd5});
    check("t1_bank_rd_en", 0, bank_rd_en_w[0], 3'b111);
    step();
    idle();
    #3;
    check("t1_rvalid", 0, row_rvalid_w[0], 3'b111);
    check("t1_rdata", 0, row_rdata_w[0], pat);
    check("t1_wr_adr", 0, slab_wr_adr_w[0], {16'd7, 16'd6, 16'd5});
    check("t1_wr_en", 0, slab_wr_en_w[0], 3'b111);
    step();
    step();
    step();

    // Rotating indices over three cycles.
    bank_rdata = pat;
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < ROWS; r++) set_row(r, 1'b1, ((r + 2 - k + 3) % 3) + 1, 16 * k + r);
      if (k == 2) begin
        #3;
        check("t2_early", 2, row_rvalid_w[2], 3'b000);
      end
      step();
    end
    idle();
    #3;
    check("t2_rvalid", 2, row_rvalid_w[2], 3'b111);
    check("t2_rdata", 2, row_rdata_w[2], {{32{8'h22}}, {32{8'h11}}, {32{8'h33}}});
    step();
    step();
    step();
    hold_data = 1'b0;

    // Rows 1 and 2 collide on bank 2.
    set_row(0, 1'b1, 2, 40);
    set_row(1, 1'b1, 2, 41);
    step();
    #3;
    check("t3_rvalid", 0, row_rvalid_w[0], 3'b001);
    check("t3_conflict", 0, conflict_w[0], 1'b1);
    check("t3_cnt", 0, conflict_cnt_w[0], 16'd1);
    for (int k = 0; k < 65540; k++) step();
    idle();
    #3;
    for (int d = 0; d < ND; d++) check("t3_sat", d, conflict_cnt_w[d], 16'hFFFF);
    step();

    // en low blocks new issue but lets earlier requests return.
    set_row(0, 1'b1, 1, 9);
    step();
    en = 1'b0;
    set_row(1, 1'b1, 2, 10);
    set_row(2, 1'b1, 3, 11);
    #3;
    check("t4_rd_en", 0, bank_rd_en_w[0], 3'b000);
    check("t4_rvalid", 0, row_rvalid_w[0], 3'b001);
    check("t4_wr_adr", 0, slab_wr_adr_w[0], {16'hFFFF, 16'hFFFF, 16'd9});
    step();
    #3;
    check("t4_drained", 0, row_rvalid_w[0], 3'b000);
    check("t4_lat2", 1, row_rvalid_w[1], 3'b001);
    step();
    en = 1'b1;
    idle();
    step();

    // Reset one cycle after issue discards the in-flight returns.
    set_row(0, 1'b1, 1, 1);
    set_row(1, 1'b1, 2, 2);
    set_row(2, 1'b1, 3, 3);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #3;
      check("t5_rvalid", 1, row_rvalid_w[1], 3'b000);
      check("t5_wr_en", 1, slab_wr_en_w[1], 3'b000);
      check("t5_wr_adr", 1, slab_wr_adr_w[1], 48'hFFFF_FFFF_FFFF);
      step();
    end

    // Mixed random traffic, checked by the model only.
    for (int k = 0; k < 200; k++) begin
      en = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < ROWS; r++) set_row(r, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 65535));
      if (k == 120) reset = 1'b1;
      if (k == 122) reset = 1'b0;
      step();
    end
    idle();
    step();
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
